// File: rtl/scan.sv
// rtl/scan.sv - sequential memory scanner: fetches bytes 0..LAST_ADDR and presents each
// on data_out with a one-cycle scan_start strobe, paced by BYTE_GAP idle cycles.
module scan #(
  parameter logic [13:0] LAST_ADDR = 14'h3FFF,
  parameter int unsigned BYTE_GAP  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  read_data,
  output logic [13:0] read_select,
  output logic [7:0]  data_out,
  output logic        scan_start
);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, LOAD, GAP, DONE} state_t;

  localparam logic [15:0] GAP_LAST = 16'(BYTE_GAP - 1);

  state_t      state_q, state_d;
  logic [13:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        pulse_q, pulse_d;
  logic [15:0] gap_q, gap_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= 14'h0000;
      data_q  <= 8'h00;
      pulse_q <= 1'b0;
      gap_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      pulse_q <= pulse_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    pulse_d = 1'b0;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        addr_d = 14'h0000;
        gap_d  = 16'h0000;
        if (start) state_d = ADDR;
      end
      ADDR: state_d = WAIT;
      WAIT: state_d = LOAD;
      LOAD: begin
        data_d  = read_data;
        pulse_d = 1'b1;
        gap_d   = 16'h0000;
        state_d = GAP;
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d = 16'h0000;
          // Compare before incrementing so the address can never wrap past LAST_ADDR.
          if (addr_q == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + 14'd1;
            state_d = ADDR;
          end
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      DONE: begin
        // Wait for start to drop so a held request yields exactly one scan.
        if (!start) begin
          addr_d  = 14'h0000;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign read_select = addr_q;
  assign data_out    = data_q;
  assign scan_start  = pulse_q;

endmodule

// File: tb/tb_scan.sv
// tb/tb_scan.sv - directed bench for scan: small instance (LAST_ADDR=3, BYTE_GAP=2)
// plus a full-range instance (BYTE_GAP=1) for the end-of-memory boundary.
module tb_scan;

  logic        clk;
  logic        rst;
  logic        start_a, start_b;
  logic [7:0]  rd_a, rd_b;
  logic [13:0] sel_a, sel_b;
  logic [7:0]  dout_a, dout_b;
  logic        ss_a, ss_b;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int c0;
  int pulse_cyc[$];
  logic [7:0] pulse_dat[$];
  int cnt_b = 0;
  logic [7:0] last_b = 8'h00;
  logic [7:0] prev_b = 8'h00;

  scan #(.LAST_ADDR(14'd3), .BYTE_GAP(2)) u_small (
    .clk(clk), .rst(rst), .start(start_a), .read_data(rd_a),
    .read_select(sel_a), .data_out(dout_a), .scan_start(ss_a)
  );

  scan #(.BYTE_GAP(1)) u_full (
    .clk(clk), .rst(rst), .start(start_b), .read_data(rd_b),
    .read_select(sel_b), .data_out(dout_b), .scan_start(ss_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: data = addr + A0, valid one clock after the address.
  always @(posedge clk) begin
    rd_a <= sel_a[7:0] + 8'hA0;
    rd_b <= sel_b[7:0] + 8'hA0;
    cyc  <= cyc + 1;
  end

  always @(negedge clk) begin
    if (ss_a) begin
      pulse_cyc.push_back(cyc);
      pulse_dat.push_back(dout_a);
    end
    if (ss_b) begin
      cnt_b  <= cnt_b + 1;
      prev_b <= last_b;
      last_b <= dout_b;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expect exactly four bytes A0..A3, first strobe in the 4th cycle after the
  // start-sampling edge, then one strobe every 5 cycles.
  task automatic check_scan(input string tag, input int edge0);
    check({tag, "_pulses"}, pulse_cyc.size(), 4);
    for (int i = 0; i < pulse_cyc.size(); i++) begin
      check({tag, "_data"}, pulse_dat[i], 8'hA0 + 8'(i));
      if (i == 0) check({tag, "_latency"}, pulse_cyc[0] - edge0, 3);
      else        check({tag, "_spacing"}, pulse_cyc[i] - pulse_cyc[i-1], 5);
    end
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b1; start_b = 1'b0;
    #2 rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("rst_sel", sel_a, 0);
      check("rst_dout", dout_a, 0);
      check("rst_ss", ss_a, 0);
    end

    // Release reset with start already high: first edge begins a held-start scan.
    pulse_cyc.delete(); pulse_dat.delete();
    rst = 1'b1;
    c0 = cyc + 1;
    repeat (30) @(negedge clk);
    check_scan("held", c0);
    check("held_done_sel", sel_a, 3);
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_sel", sel_a, 0);

    pulse_cyc.delete(); pulse_dat.delete();
    start_a = 1'b1;
    c0 = cyc + 1;
    repeat (30) @(negedge clk);
    check_scan("rescan", c0);

    // Drop start during WAIT of address 1; the scan must run to completion.
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    pulse_cyc.delete(); pulse_dat.delete();
    start_a = 1'b1;
    c0 = cyc + 1;
    repeat (7) @(negedge clk);
    check("wait1_sel", sel_a, 1);
    start_a = 1'b0;
    repeat (30) @(negedge clk);
    check_scan("drop", c0);
    check("drop_idle_sel", sel_a, 0);

    // Reset asserted in the GAP of address 2.
    pulse_cyc.delete(); pulse_dat.delete();
    start_a = 1'b1;
    repeat (14) @(negedge clk);
    check("gap2_ss", ss_a, 1);
    check("gap2_dout", dout_a, 8'hA2);
    check("gap2_sel", sel_a, 2);
    #1 rst = 1'b0;
    #1;
    check("async_sel", sel_a, 0);
    check("async_dout", dout_a, 0);
    check("async_ss", ss_a, 0);
    repeat (2) @(negedge clk);
    pulse_cyc.delete(); pulse_dat.delete();
    rst = 1'b1;
    c0 = cyc + 1;
    repeat (30) @(negedge clk);
    check_scan("post_rst", c0);
    start_a = 1'b0;

    // Full 16K scan on the default-range instance: ends at 3FFF without wrapping.
    start_b = 1'b1;
    repeat (65600) @(negedge clk);
    check("full_pulses", cnt_b, 16384);
    check("full_3ffe", prev_b, 8'h9E);
    check("full_3fff", last_b, 8'h9F);
    check("full_sel", sel_b, 14'h3FFF);
    repeat (50) @(negedge clk);
    check("full_hold_pulses", cnt_b, 16384);
    check("full_hold_sel", sel_b, 14'h3FFF);
    check("full_hold_dout", dout_b, 8'h9F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scan.md
SCAN -- requirements
Module: scan

Interface
REQ-001 The block SHALL have parameter LAST_ADDR, default 14'h3FFF, meaning the final memory address scanned (inclusive).
REQ-002 The block SHALL have parameter BYTE_GAP, default 16, meaning the number of idle cycles inserted after each byte is presented (pacing for the downstream UART transmitter); legal range 1..65535.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low: rst=0 resets, rst=1 runs.
REQ-005 start  input  1  level request to begin one full memory scan.
REQ-006 read_data  input  8  byte returned by external memory for the address on read_select, valid one clock after the address.
REQ-007 read_select  output  14  registered memory read address.
REQ-008 data_out  output  8  registered copy of the most recently fetched byte.
REQ-009 scan_start  output  1  one-cycle pulse marking a new valid byte on data_out.

Function
REQ-010 The FSM SHALL have states IDLE, ADDR, WAIT, LOAD, GAP, DONE.
REQ-011 IDLE: read_select held at 0; start=1 sampled on a rising edge SHALL move to ADDR; start=0 SHALL keep IDLE.
REQ-012 ADDR: read_select SHALL hold the current address; next state WAIT (one cycle covering the memory read latency).
REQ-013 WAIT: next state LOAD.
REQ-014 LOAD: on the LOAD edge data_out SHALL capture read_data; scan_start SHALL be 1 for exactly the cycle following that edge; next state GAP.
REQ-015 GAP: an internal 16-bit counter SHALL count BYTE_GAP cycles; on expiry, if address==LAST_ADDR the next state SHALL be DONE, else the address SHALL increment by 1 and the next state SHALL be ADDR.
REQ-016 Byte period SHALL be exactly 3+BYTE_GAP cycles; the first scan_start SHALL assert 4 cycles after the edge on which start is sampled high in IDLE.
REQ-017 start SHALL be ignored in all states other than IDLE and DONE; deasserting start mid-scan SHALL NOT abort the scan.
REQ-018 DONE: outputs SHALL hold their last values; the FSM SHALL return to IDLE only after start is sampled 0, so a start held high produces exactly one scan.
REQ-019 The address SHALL never wrap: with LAST_ADDR=14'h3FFF the scan ends at 3FFF and never increments to 0000.
REQ-020 scan_start SHALL never assert outside the LOAD-to-GAP transition cycle; exactly LAST_ADDR+1 pulses SHALL occur per scan.

Reset
REQ-021 While rst=0, regardless of clk, the state SHALL be IDLE, read_select=14'h0000, data_out=8'h00, scan_start=0, and the gap counter 0.
REQ-022 Assertion of rst mid-scan SHALL abort immediately; after release the block SHALL wait in IDLE and restart from address 0 on start=1.
REQ-023 After rst rises, start already high SHALL be sampled on the first rising edge, beginning a scan.

Verification
REQ-024 rst=0, start=1, read_data=0 for 100 ns -> read_select=0, data_out=0, scan_start=0 throughout.
REQ-025 LAST_ADDR=3, BYTE_GAP=2, memory returns data=addr+8'hA0, start pulsed -> data_out A0,A1,A2,A3 with 4 scan_start pulses spaced 5 cycles, then DONE.
REQ-026 Same setup, start held 1 -> exactly 4 pulses; drop start then raise again -> a second scan of 4 pulses starting at address 0.
REQ-027 Default parameters, force address 3FFE via scan progress -> pulses for 3FFE and 3FFF, then DONE, read_select stays 3FFF, no wrap to 0.
REQ-028 rst driven 0 during GAP of address 2 -> all outputs cleared asynchronously before next edge; after release with start=1, first byte fetched is address 0.
REQ-029 start deasserted during WAIT of address 1 -> scan continues to LAST_ADDR unchanged.
